scene_reg_bank: RTL and testbench

Parametrised, double-buffered scene register bank that sits between the UART input assembler and the vertex-shader/raster pipeline. It assembles byte-indexed writes into 16-bit words in a shadow bank. On a frame boundary it commits the shadow bank atomically to the active bank, so scene parameters never change mid-frame. It also flags protocol errors: out-of-range indices and writes landing while a commit is pending.

---
 rtl/scene_reg_bank_if.sv | 13 +
 rtl/scene_reg_bank.sv | 109 ++++++++++
 tb/tb_scene_reg_bank.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/scene_reg_bank_if.sv
// Upload-side bus from the UART input assembler into scene_reg_bank:
// byte-write strobe, byte index, write data and the end-of-upload pulse.
interface scene_reg_bank_if #(
  parameter int IDX_W = 6
);
  logic             update_reg;
  logic [IDX_W-1:0] idx;
  logic [7:0]       read_data;
  logic             pc_ready;

  modport master (output update_reg, idx, read_data, pc_ready);
  modport slave  (input  update_reg, idx, read_data, pc_ready);
endinterface

// File: rtl/scene_reg_bank.sv
// Scene register bank: byte-indexed writes assembled into 16-bit words.
// Build option SCENE_REG_SHADOW_EN: shadow bank committed atomically at frame_start; undefined = legacy single bank.
module scene_reg_bank #(
  parameter int NUM_WORDS = 31,
  parameter int IDX_W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  scene_reg_bank_if.slave        wr,
  input  logic                   frame_start,
  input  logic                   err_clr,
  output logic [16*NUM_WORDS-1:0] active_regs,
  output logic                   pc_data_ready,
  output logic                   pending,
  output logic                   bad_idx,
  output logic                   overrun
);
  localparam int              BANK_W     = 16 * NUM_WORDS;
  localparam logic [IDX_W:0]  BYTE_LIMIT = (IDX_W + 1)'(2 * NUM_WORDS);

  logic              in_range;
  logic              wr_en;
  logic [BANK_W-1:0] wr_base;
  logic [BANK_W-1:0] wr_next;

  assign in_range = ({1'b0, wr.idx} < BYTE_LIMIT);

  // Next-state of the written bank: one byte replaced, its partner byte kept.
  always_comb begin
    wr_next = wr_base;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (wr_en && (wr.idx[IDX_W-1:1] == (IDX_W - 1)'(k))) begin
        if (wr.idx[0])
          wr_next[16*k+8 +: 8] = wr.read_data;
        else
          wr_next[16*k +: 8] = wr.read_data;
      end
    end
  end

  // Error event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      bad_idx <= 1'b0;
    else if (wr.update_reg && !in_range)
      bad_idx <= 1'b1;
    else if (err_clr)
      bad_idx <= 1'b0;
  end

`ifdef SCENE_REG_SHADOW_EN
  typedef enum logic {IDLE, PENDING} pend_state_t;

  pend_state_t       state;
  logic [BANK_W-1:0] shadow_q;
  logic              commit;

  assign wr_en   = wr.update_reg && in_range && (state == IDLE);
  assign wr_base = shadow_q;
  assign commit  = frame_start && ((state == PENDING) || wr.pc_ready);
  assign pending = (state == PENDING);

  // Commit loads wr_next so a byte accepted on the commit edge is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shadow_q      <= '0;
      active_regs   <= '0;
      pc_data_ready <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      shadow_q      <= wr_next;
      pc_data_ready <= commit;
      if (commit)
        active_regs <= wr_next;

      case (state)
        IDLE:    if (wr.pc_ready && !frame_start) state <= PENDING;
        PENDING: if (frame_start)                 state <= IDLE;
        default:                                  state <= IDLE;
      endcase

      if (wr.update_reg && (state == PENDING))
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
    end
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign wr_en   = wr.update_reg && in_range;
  assign wr_base = active_regs;
  assign pending = 1'b0;
  assign overrun = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_regs   <= '0;
      pc_data_ready <= 1'b0;
    end else begin
      active_regs   <= wr_next;
      pc_data_ready <= wr.pc_ready;
    end
  end
`endif

endmodule

// File: tb/tb_scene_reg_bank.sv
// Scoreboard bench for scene_reg_bank: stimulus pushes the expected active bank for each
// pc_data_ready pulse; a negedge monitor pops and compares. Expectations follow SCENE_REG_SHADOW_EN.
module tb_scene_reg_bank;
  localparam int NUM_WORDS = 31;
  localparam int IDX_W     = 6;
  localparam int VW        = 16 * NUM_WORDS;
`ifdef SCENE_REG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          frame_start;
  logic          err_clr;
  logic [VW-1:0] active_regs;
  logic          pc_data_ready;
  logic          pending;
  logic          bad_idx;
  logic          overrun;

  int checks = 0;
  int fails  = 0;
  logic [VW-1:0] exp_q[$];

  scene_reg_bank_if #(.IDX_W(IDX_W)) wr_if ();

  scene_reg_bank #(.NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr_if),
    .frame_start  (frame_start),
    .err_clr      (err_clr),
    .active_regs  (active_regs),
    .pc_data_ready(pc_data_ready),
    .pending      (pending),
    .bad_idx      (bad_idx),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                       input logic [15:0] w2);
    logic [VW-1:0] v;
    v        = '0;
    v[15:0]  = w0;
    v[31:16] = w1;
    v[47:32] = w2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bank(input string name, input logic [VW-1:0] exp);
    checks++;
    if (active_regs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, active_regs, exp);
    end
  endtask

  // Inputs applied at a negedge, held across one posedge, outputs sampled at the next negedge.
  task automatic cyc(input logic upd, input logic [IDX_W-1:0] i, input logic [7:0] d,
                     input logic pcr, input logic fs, input logic clr, input logic rst);
    wr_if.update_reg = upd;
    wr_if.idx        = i;
    wr_if.read_data  = d;
    wr_if.pc_ready   = pcr;
    frame_start      = fs;
    err_clr          = clr;
    reset            = rst;
    @(negedge clk);
  endtask

  task automatic wrb(input logic [IDX_W-1:0] i, input logic [7:0] d);
    cyc(1'b1, i, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic pcr();  cyc(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic fs();   cyc(1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle(); cyc(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  always @(negedge clk) begin
    if (pc_data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pc_data_ready: got 1, expected 0");
      end else begin
        chk_bank("bank_at_pc_data_ready", exp_q.pop_front());
      end
    end
  end

  initial begin
    cyc(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_bank("reset_bank", '0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_pc_data_ready", 32'(pc_data_ready), 0);
    chk("reset_bad_idx", 32'(bad_idx), 0);
    chk("reset_overrun", 32'(overrun), 0);

    // Byte assembly
    wrb(6'd0, 8'h34);
    wrb(6'd1, 8'h12);
    chk_bank("assembly_before_commit", SHADOW ? '0 : mk(16'h1234, 0, 0));
    exp_q.push_back(mk(16'h1234, 0, 0));
    pcr();
    chk("assembly_pending", 32'(pending), 32'(SHADOW));
    fs();
    chk_bank("assembly_after_commit", mk(16'h1234, 0, 0));
    chk("assembly_pending_clear", 32'(pending), 0);

    // Atomicity
    wrb(6'd0, 8'hAA);
    wrb(6'd1, 8'hBB);
    exp_q.push_back(mk(16'hBBAA, 0, 0));
    pcr();
    chk_bank("atomic_hold", SHADOW ? mk(16'h1234, 0, 0) : mk(16'hBBAA, 0, 0));
    chk("atomic_pending", 32'(pending), 32'(SHADOW));
    idle();
    chk_bank("atomic_hold_idle", SHADOW ? mk(16'h1234, 0, 0) : mk(16'hBBAA, 0, 0));
    fs();
    chk_bank("atomic_commit", mk(16'hBBAA, 0, 0));
    chk("atomic_pending_clear", 32'(pending), 0);

    // Overrun
    exp_q.push_back(mk(16'hBBAA, 0, 0));
    pcr();
    wrb(6'd2, 8'h55);
    chk("overrun_set", 32'(overrun), 32'(SHADOW));
    fs();
    chk_bank("overrun_word1", SHADOW ? mk(16'hBBAA, 0, 0) : mk(16'hBBAA, 16'h0055, 0));
    cyc(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("overrun_clear", 32'(overrun), 0);

    // Bad index, then sticky-wins against a simultaneous clear
    wrb(6'd62, 8'hFF);
    chk("bad_idx_set", 32'(bad_idx), 1);
    exp_q.push_back(SHADOW ? mk(16'hBBAA, 0, 0) : mk(16'hBBAA, 16'h0055, 0));
    pcr();
    fs();
    chk_bank("bad_idx_no_change", SHADOW ? mk(16'hBBAA, 0, 0) : mk(16'hBBAA, 16'h0055, 0));
    cyc(1'b1, 6'd63, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bad_idx_event_wins", 32'(bad_idx), 1);
    cyc(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bad_idx_clear", 32'(bad_idx), 0);
    chk("overrun_unaffected", 32'(overrun), 0);

    // Coincident write, pc_ready and frame_start
    exp_q.push_back(SHADOW ? mk(16'hBBAA, 0, 16'h0077) : mk(16'hBBAA, 16'h0055, 16'h0077));
    cyc(1'b1, 6'd4, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("coincident_pending_low", 32'(pending), 0);
    chk_bank("coincident_bank", SHADOW ? mk(16'hBBAA, 0, 16'h0077)
                                       : mk(16'hBBAA, 16'h0055, 16'h0077));

    // Reset mid-upload
    wrb(6'd0, 8'h11);
    if (!SHADOW) exp_q.push_back(mk(16'hBB11, 16'h0055, 16'h0077));
    pcr();
    chk("midupload_pending", 32'(pending), 32'(SHADOW));
    cyc(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_bank("midupload_reset_bank", '0);
    chk("midupload_reset_pending", 32'(pending), 0);
    fs();
    chk_bank("midupload_no_commit", '0);
    idle();
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
